// File: rtl/ysyx_22050612_ifu_pkg.sv
// Shared types and constants for the ysyx_22050612 instruction fetch unit.
package ysyx_22050612_ifu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_ERR
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: one aligned doubleword read per instruction, word select by pc[2],
// valid/ready hand-off to execute, and redirect handling that drops stale in-flight fetches.
module ysyx_22050612_ifu
  import ysyx_22050612_ifu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  output logic [XLEN-1:0]   mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              fetch_misalign
);

  ifu_state_e        state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              misalign_q, misalign_d;
  logic              err_pend_q, err_pend_d;
  logic              req_fire;
  logic              resp_open;
  logic              redirect_bad;

  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_req_addr   = {pc_q[XLEN-1:3], 3'b000};
  assign inst_valid     = (state_q == S_HOLD) && !redirect_valid;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_misalign = misalign_q;

  assign req_fire     = mem_req_valid && mem_req_ready;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    misalign_d = misalign_q;
    err_pend_d = err_pend_q;

    // Whether a response is still owed after this cycle; needed when halting into S_ERR.
    case (state_q)
      S_REQ:           resp_open = req_fire;
      S_WAIT, S_DRAIN: resp_open = !mem_resp_valid;
      S_ERR:           resp_open = err_pend_q && !mem_resp_valid;
      default:         resp_open = 1'b0;
    endcase

    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (redirect_bad || (state_q == S_ERR)) begin
        misalign_d = misalign_q | redirect_bad;
        state_d    = S_ERR;
        err_pend_d = resp_open;
      end else begin
        case (state_q)
          S_REQ:   state_d = req_fire ? S_DRAIN : S_REQ;
          S_WAIT:  state_d = mem_resp_valid ? S_REQ : S_DRAIN;
          S_HOLD:  state_d = S_REQ;
          S_DRAIN: state_d = mem_resp_valid ? S_REQ : S_DRAIN;
          default: state_d = state_q;
        endcase
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            inst_d    = pc_q[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc_d    = pc_q + 64'd4;
            state_d = S_REQ;
          end
        end
        S_DRAIN: begin
          if (mem_resp_valid) state_d = S_REQ;
        end
        S_ERR: begin
          err_pend_d = err_pend_q && !mem_resp_valid;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      misalign_q <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      misalign_q <= misalign_d;
      err_pend_q <= err_pend_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Self-checking bench for ysyx_22050612_ifu: directed scenarios then randomized traffic,
// all checked against a transaction-level model (pc, in-flight fetch, held instruction).
module tb_ysyx_22050612_ifu;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_misalign;

  ysyx_22050612_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass;
  int unsigned n_total;

  // Reference model state
  logic [63:0] m_pc;
  logic        m_held;
  logic        m_infl;
  logic        m_stale;
  logic        m_halt;
  logic        m_mis;
  logic [31:0] m_inst;
  logic [63:0] m_inst_pc;
  logic [63:0] m_fetch_pc;
  int          mem_cnt;
  int          resp_delay;

  // Last observed outputs, for directed checks against literal expectations
  logic        obs_req;
  logic [63:0] obs_addr;
  logic        obs_ivalid;
  logic [31:0] obs_inst;
  logic [63:0] obs_ipc;
  logic        obs_mis;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h00000013_00100093;
    return {a[31:0] * 32'h9E37_79B1, a[31:0] ^ 32'hA5A5_5A5A};
  endfunction

  function automatic logic [63:0] align8(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

  task automatic observe();
    obs_req    = mem_req_valid;
    obs_addr   = mem_req_addr;
    obs_ivalid = inst_valid;
    obs_inst   = inst;
    obs_ipc    = inst_pc;
    obs_mis    = fetch_misalign;
  endtask

  task automatic compare_outputs();
    logic exp_req;
    exp_req = !m_halt && !m_infl && !m_held;
    check_val("req_valid", 64'(mem_req_valid), 64'(exp_req));
    check_val("req_addr", mem_req_addr, align8(m_pc));
    check_val("inst_valid", 64'(inst_valid), 64'(m_held && !redirect_valid));
    check_val("inst", 64'(inst), 64'(m_inst));
    check_val("inst_pc", inst_pc, m_inst_pc);
    check_val("misalign", 64'(fetch_misalign), 64'(m_mis));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    inst_ready     = 1'b0;
    m_pc      = 64'h8000_0000;
    m_held    = 1'b0;
    m_infl    = 1'b0;
    m_stale   = 1'b0;
    m_halt    = 1'b0;
    m_mis     = 1'b0;
    m_inst    = '0;
    m_inst_pc = '0;
    mem_cnt   = 0;
    #1;
    compare_outputs();
    observe();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cycle(input logic rv, input logic [63:0] rpc, input logic rdy, input logic irdy);
    logic        resp;
    logic        acc;
    logic        hs;
    logic [63:0] word;
    @(negedge clk);
    resp           = m_infl && (mem_cnt == 0);
    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_req_ready  = rdy;
    inst_ready     = irdy;
    mem_resp_valid = resp;
    mem_resp_data  = resp ? mem_word(align8(m_fetch_pc)) : 64'h0;
    #1;
    compare_outputs();
    observe();

    acc = !m_halt && !m_infl && !m_held && rdy;
    hs  = m_held && !rv && irdy;
    if (resp) begin
      if (!m_stale && !rv) begin
        word      = mem_word(align8(m_fetch_pc));
        m_inst    = m_fetch_pc[2] ? word[63:32] : word[31:0];
        m_inst_pc = m_fetch_pc;
        m_held    = 1'b1;
      end
      m_infl = 1'b0;
    end else if (m_infl) begin
      mem_cnt--;
    end
    if (acc) begin
      m_infl     = 1'b1;
      m_stale    = rv;
      m_fetch_pc = m_pc;
      mem_cnt    = (resp_delay < 0) ? int'($urandom_range(0, 2)) : resp_delay;
    end else if (rv && m_infl) begin
      m_stale = 1'b1;
    end
    if (rv) begin
      m_pc   = rpc;
      m_held = 1'b0;
      if (rpc[1:0] != 2'b00) begin
        m_halt = 1'b1;
        m_mis  = 1'b1;
      end
    end else if (hs) begin
      m_pc   = m_pc + 64'd4;
      m_held = 1'b0;
    end
  endtask

  initial begin
    int          halt_cycles;
    logic        rv;
    logic [63:0] rpc;
    n_pass         = 0;
    n_total        = 0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    inst_ready     = 1'b0;
    resp_delay     = 0;

    do_reset();
    check_val("rst_addr", obs_addr, 64'h8000_0000);
    check_val("rst_ivalid", 64'(obs_ivalid), 64'h0);

    // Basic fetch of both halves of one doubleword
    cycle(1'b0, '0, 1'b1, 1'b1);
    check_val("t1_addr0", obs_addr, 64'h8000_0000);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check_val("t1_ivalid", 64'(obs_ivalid), 64'h1);
    check_val("t1_inst0", 64'(obs_inst), 64'h0010_0093);
    check_val("t1_pc0", obs_ipc, 64'h8000_0000);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("t1_addr1", obs_addr, 64'h8000_0000);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Backpressure for five cycles
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_val("t2_inst1", 64'(obs_inst), 64'h0000_0013);
      check_val("t2_pc1", obs_ipc, 64'h8000_0004);
      check_val("t2_noreq", 64'(obs_req), 64'h0);
    end
    cycle(1'b0, '0, 1'b1, 1'b1);
    resp_delay = 1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("t2_addr2", obs_addr, 64'h8000_0008);

    // Redirect while waiting; late response must be dropped
    cycle(1'b1, 64'h8000_1000, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_val("t3_drop", 64'(obs_ivalid), 64'h0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_val("t3_req", 64'(obs_req), 64'h1);
    check_val("t3_addr", obs_addr, 64'h8000_1000);

    // Redirect coincident with response
    resp_delay = 0;
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 64'h8000_2000, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_val("t4_req", 64'(obs_req), 64'h1);
    check_val("t4_addr", obs_addr, 64'h8000_2000);

    // Redirect on the accepting cycle: one response swallowed
    cycle(1'b1, 64'h8000_3000, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("t5_drain", 64'(obs_req), 64'h0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("t5_req", 64'(obs_req), 64'h1);
    check_val("t5_addr", obs_addr, 64'h8000_3000);

    // Misaligned redirect halts until reset
    cycle(1'b1, 64'h8000_0002, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b1);
      check_val("t6_mis", 64'(obs_mis), 64'h1);
      check_val("t6_noreq", 64'(obs_req), 64'h0);
    end
    do_reset();
    check_val("t6_mis_clr", 64'(obs_mis), 64'h0);
    check_val("t6_addr", obs_addr, 64'h8000_0000);

    // Randomized traffic
    resp_delay  = -1;
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_halt) begin
        halt_cycles++;
        if (halt_cycles > 8) begin
          do_reset();
          halt_cycles = 0;
          continue;
        end
      end
      rv  = ($urandom_range(0, 5) == 0);
      rpc = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
      if ($urandom_range(0, 19) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
      if ($urandom_range(0, 29) == 0) rpc = rpc | 64'($urandom_range(1, 3));
      cycle(rv, rpc, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_ifu.md
Name: ysyx_22050612_ifu

Overview:
Instruction fetch unit sitting directly upstream of the execute stage. Holds the architectural PC and issues one 8-byte-aligned read per instruction to the memory port. It extracts the 32-bit instruction word from the returned doubleword and presents it with its PC to decode/execute over a valid/ready handshake. It accepts next-PC redirects (dnpc) from execute and discards any in-flight stale fetch.

Parameters:
RESET_PC  64'h8000_0000  PC loaded on reset
XLEN  64  address/data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
mem_req_valid  out  1  fetch request valid
mem_req_addr  out  XLEN  {pc[63:3],3'b0}
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  read data valid, one pulse per accepted request
mem_resp_data  in  XLEN  doubleword read data
inst_valid  out  1  instruction available to consumer
inst  out  32  instruction word
inst_pc  out  XLEN  PC of inst
inst_ready  in  1  consumer accepts instruction
redirect_valid  in  1  execute supplies next PC
redirect_pc  in  XLEN  next PC (dnpc)
fetch_misalign  out  1  sticky: redirect_pc[1:0]!=0 seen

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=S_REQ, inst=0, inst_pc=0, inst_valid=0, fetch_misalign=0. mem_req_valid is 1 in the first clk edge after rst deasserts.
- States: S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_ERR. mem_req_valid=(state==S_REQ); inst_valid=(state==S_HOLD) && !redirect_valid.
- Redirect has priority over every other event in every state: pc<=redirect_pc. If redirect_pc[1:0]!=0, set fetch_misalign and go to S_ERR, then apply the S_DRAIN rule below before halting.
- S_REQ: on mem_req_valid&&mem_req_ready go to S_WAIT. If a redirect arrives in the same cycle as acceptance, go to S_DRAIN. A redirect without acceptance stays in S_REQ, with the address changed to the new pc. mem_resp_valid in S_REQ is ignored.
- S_WAIT: on mem_resp_valid, latch inst=pc[2]?data[63:32]:data[31:0] and inst_pc=pc, then go to S_HOLD.
  - Redirect without resp: go to S_DRAIN.
  - Redirect with resp in the same cycle: discard the data and go to S_REQ.
- S_DRAIN: wait for mem_resp_valid, discard it, then go to S_REQ. A redirect here only updates pc.
- S_HOLD: on inst_valid&&inst_ready, pc<=pc+4 (XLEN wrap, no carry out) and go to S_REQ. A redirect in S_HOLD drops the held instruction and goes to S_REQ; it is not a handshake. inst/inst_pc stay stable while held.
- S_ERR: no requests, inst_valid=0. Only rst exits. Before halting, it waits for any outstanding response (same rule as S_DRAIN).
- At most one request is outstanding. The response arrives no earlier than the cycle after acceptance.
- Minimum throughput is 3 cycles per instruction (REQ, WAIT, HOLD).
- Reset mid-fetch: the state machine returns to S_REQ immediately. The memory side is also reset by the same rst, so no stale response is expected.

Decomposition:
- Shared package: state enum (S_REQ..S_ERR), RESET_PC, XLEN, INST_W=32.
- No sub-module. The half-word select is one inline mux, and the state machine and PC register share one always block pair (seq/comb).

Test Plan:
1. Basic fetch: reset released; mem_req_ready=1; resp one cycle after accept with data 64'h00000013_00100093. Required: mem_req_addr=0x80000000, then inst=0x00100093, inst_pc=0x80000000, inst_valid=1. After inst_ready, the next addr is 0x80000000 with inst 0x00000013 and inst_pc 0x80000004.
2. Backpressure: hold inst_ready=0 for 5 cycles in S_HOLD. Required: inst/inst_pc/inst_valid stable, no new mem_req_valid, and the pc advances by exactly 4 after release.
3. Redirect in S_WAIT, resp 2 cycles later: redirect_pc=0x80001000. Required: the late resp is discarded (inst_valid stays 0) and the next request addr is 0x80001000.
4. Redirect coincident with resp in S_WAIT. Required: data discarded, no S_DRAIN, and a request to the redirect pc the next cycle.
5. Redirect with mem_req_ready=1 in S_REQ. Required: S_DRAIN, one response swallowed, then a request to the new pc.
6. Misaligned redirect_pc=0x80000002. Required: fetch_misalign=1 sticky, no further mem_req_valid until rst pulse. After rst, fetch_misalign=0 and pc=0x80000000.
